// File: rtl/alu_issue_stage.sv
// alu_issue_stage: operand-fetch / write-back stage around a combinational alu.
//
// An instruction is accepted over a valid/ready handshake. Its operands are
// read from an internal register file and registered towards the alu, and the
// alu result is written back one edge later. A direct load port initialises
// registers and a combinational debug port reads the file.
//
// Build option (macro ALU_ISSUE_BYPASS_EN):
//   defined   - an instruction whose source matches the register being
//               written back on the same edge takes the alu result directly.
//   undefined - no bypass mux. Such an instruction is stalled for one cycle
//               and then reads the already updated register file.
// Architectural results are identical in both builds.

module alu_issue_stage #(
    parameter int BW    = 16,
    parameter int NREGS = 8,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    // instruction handshake
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [2:0]    instr_opcode,
    input  logic [AW-1:0] instr_rd,
    input  logic [AW-1:0] instr_rs1,
    input  logic [AW-1:0] instr_rs2,
    // direct register load
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_addr,
    input  logic [BW-1:0] ld_data,
    // alu interface
    output logic [BW-1:0] alu_in_a,
    output logic [BW-1:0] alu_in_b,
    output logic [2:0]    alu_opcode,
    input  logic [BW:0]   alu_out,
    input  logic [2:0]    alu_flags,
    // write-back report
    output logic          wb_valid,
    output logic [AW-1:0] wb_addr,
    output logic [BW-1:0] wb_data,
    output logic [2:0]    flags_q,
    // debug read
    input  logic [AW-1:0] dbg_addr,
    output logic [BW-1:0] dbg_data
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [BW-1:0] r_rf [NREGS];     // architectural register file
    logic          r_iss_v;          // an instruction sits in the alu this cycle
    logic [AW-1:0] r_iss_rd;         // its destination register
    logic [BW-1:0] r_alu_in_a;
    logic [BW-1:0] r_alu_in_b;
    logic [2:0]    r_alu_opcode;
    logic          r_wb_valid;
    logic [AW-1:0] r_wb_addr;
    logic [BW-1:0] r_wb_data;
    logic [2:0]    r_flags_q;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic [BW-1:0] w_res;            // alu result truncated to register width
    logic          w_unused_msb;     // alu carry-out bit, intentionally dropped
    logic          w_hazard;         // instruction must wait one cycle
    logic          w_instr_fire;
    logic          w_ld_fire;
    logic [BW-1:0] w_opa;
    logic [BW-1:0] w_opb;

    assign w_res        = alu_out[BW-1:0];
    assign w_unused_msb = alu_out[BW];

    // Loads are only taken while the alu slot is empty, so a load and a
    // write-back never target the register file on the same edge.
    assign ld_ready     = ~r_iss_v;
    assign w_ld_fire    = ld_valid & ~r_iss_v;

    // Loads have priority over instructions; a hazard adds a stall when the
    // bypass network is absent.
    assign instr_ready  = ~ld_valid & ~w_hazard;
    assign w_instr_fire = instr_valid & instr_ready;

`ifdef ALU_ISSUE_BYPASS_EN
    // Operand select: a source matching the register written back on this
    // edge takes the alu result instead of the stale file entry.
    always_comb begin
        w_hazard = 1'b0;
        if (r_iss_v && (instr_rs1 == r_iss_rd)) begin
            w_opa = w_res;
        end else begin
            w_opa = r_rf[instr_rs1];
        end
        if (r_iss_v && (instr_rs2 == r_iss_rd)) begin
            w_opb = w_res;
        end else begin
            w_opb = r_rf[instr_rs2];
        end
    end
`else
    // Operand select: plain file read; a dependent instruction is held off
    // for one cycle so the file already holds the new value when it issues.
    always_comb begin
        w_opa = r_rf[instr_rs1];
        w_opb = r_rf[instr_rs2];
        if (r_iss_v && ((instr_rs1 == r_iss_rd) || (instr_rs2 == r_iss_rd))) begin
            w_hazard = 1'b1;
        end else begin
            w_hazard = 1'b0;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Register file: write-back from the alu or a direct load
    // ------------------------------------------------------------------

    // Register file update; write-back and load are mutually exclusive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_rf[i] <= '0;
            end
        end else if (r_iss_v) begin
            r_rf[r_iss_rd] <= w_res;
        end else if (w_ld_fire) begin
            r_rf[ld_addr] <= ld_data;
        end
    end

    assign dbg_data = r_rf[dbg_addr];

    // ------------------------------------------------------------------
    // Issue stage (E0): register operands and opcode towards the alu
    // ------------------------------------------------------------------

    // Issue register; alu inputs hold their last value while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iss_v      <= 1'b0;
            r_iss_rd     <= '0;
            r_alu_in_a   <= '0;
            r_alu_in_b   <= '0;
            r_alu_opcode <= 3'd0;
        end else if (w_instr_fire) begin
            r_iss_v      <= 1'b1;
            r_iss_rd     <= instr_rd;
            r_alu_in_a   <= w_opa;
            r_alu_in_b   <= w_opb;
            r_alu_opcode <= instr_opcode;
        end else begin
            r_iss_v      <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Write-back stage (E1): capture the alu result and flags
    // ------------------------------------------------------------------

    // Write-back report; address, data and flags only change on write-back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_valid <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
            r_flags_q  <= 3'd0;
        end else if (r_iss_v) begin
            r_wb_valid <= 1'b1;
            r_wb_addr  <= r_iss_rd;
            r_wb_data  <= w_res;
            r_flags_q  <= alu_flags;
        end else begin
            r_wb_valid <= 1'b0;
        end
    end

    assign alu_in_a   = r_alu_in_a;
    assign alu_in_b   = r_alu_in_b;
    assign alu_opcode = r_alu_opcode;
    assign wb_valid   = r_wb_valid;
    assign wb_addr    = r_wb_addr;
    assign wb_data    = r_wb_data;
    assign flags_q    = r_flags_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage with a stub adder alu.
// Honors ALU_ISSUE_BYPASS_EN to pick the expected stall behaviour.

module tb_alu_issue_stage;

    localparam int BW    = 16;
    localparam int NREGS = 8;
    localparam int AW    = 3;
`ifdef ALU_ISSUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          instr_valid;
    logic          instr_ready;
    logic [2:0]    instr_opcode;
    logic [AW-1:0] instr_rd;
    logic [AW-1:0] instr_rs1;
    logic [AW-1:0] instr_rs2;
    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_addr;
    logic [BW-1:0] ld_data;
    logic [BW-1:0] alu_in_a;
    logic [BW-1:0] alu_in_b;
    logic [2:0]    alu_opcode;
    logic [BW:0]   alu_out;
    logic [2:0]    alu_flags;
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [BW-1:0] wb_data;
    logic [2:0]    flags_q;
    logic [AW-1:0] dbg_addr;
    logic [BW-1:0] dbg_data;

    int checks   = 0;
    int failures = 0;

    alu_issue_stage dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_opcode(instr_opcode), .instr_rd(instr_rd),
        .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
        .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_opcode(alu_opcode),
        .alu_out(alu_out), .alu_flags(alu_flags),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .flags_q(flags_q), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Stub alu: sign-extended add regardless of opcode.
    logic [BW:0] stub_sum;
    assign stub_sum  = {alu_in_a[BW-1], alu_in_a} + {alu_in_b[BW-1], alu_in_b};
    assign alu_out   = stub_sum;
    assign alu_flags = {(alu_in_a[BW-1] == alu_in_b[BW-1]) && (stub_sum[BW-1] != alu_in_a[BW-1]),
                        stub_sum[BW-1],
                        stub_sum[BW-1:0] == 16'd0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Reference: signed add, returns {ovf, neg, zero, result[15:0]}.
    function automatic logic [18:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        int s;
        int w;
        logic ovf, neg, zr;
        s   = int'($signed(a)) + int'($signed(b));
        ovf = (s > 32767) || (s < -32768);
        w   = s;
        if (w > 32767) w = w - 65536;
        else if (w < -32768) w = w + 65536;
        neg = (w < 0);
        zr  = (w == 0);
        return {ovf, neg, zr, 16'(w)};
    endfunction

    task automatic idle_inputs();
        instr_valid = 1'b0; instr_opcode = 3'd0; instr_rd = '0; instr_rs1 = '0; instr_rs2 = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
    endtask

    task automatic load_reg(input logic [AW-1:0] a, input logic [BW-1:0] d);
        @(negedge clk);
        ld_valid = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (flags_q !== 3'd0) begin failures++; $display("FAIL reset_flags got=%h exp=0", flags_q); end
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); end
        checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL reset_instr_ready got=%b exp=1", instr_ready); end
        checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL reset_ld_ready got=%b exp=1", ld_ready); end
        for (int a = 0; a < NREGS; a++) begin
            @(negedge clk);
            dbg_addr = AW'(a);
            #1;
            checks++; if (dbg_data !== 16'd0) begin failures++; $display("FAIL reset_dbg r%0d got=%h exp=0", a, dbg_data); end
        end
    endtask

    task automatic test_basic();
        load_reg(3'd1, 16'd5);
        load_reg(3'd2, 16'hFFFD);
        instr_valid = 1'b1; instr_opcode = 3'd0; instr_rd = 3'd3; instr_rs1 = 3'd1; instr_rs2 = 3'd2;
        #1;
        checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL basic_ready got=%b exp=1", instr_ready); end
        @(negedge clk);
        instr_valid = 1'b0;
        #1;
        checks++; if (alu_in_a !== 16'd5) begin failures++; $display("FAIL basic_in_a got=%h exp=0005", alu_in_a); end
        checks++; if (alu_in_b !== 16'hFFFD) begin failures++; $display("FAIL basic_in_b got=%h exp=fffd", alu_in_b); end
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL basic_wb_early got=%b exp=0", wb_valid); end
        @(negedge clk);
        dbg_addr = 3'd3;
        #1;
        checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL basic_wb_valid got=%b exp=1", wb_valid); end
        checks++; if (wb_addr !== 3'd3) begin failures++; $display("FAIL basic_wb_addr got=%h exp=3", wb_addr); end
        checks++; if (wb_data !== 16'd2) begin failures++; $display("FAIL basic_wb_data got=%h exp=0002", wb_data); end
        checks++; if (flags_q !== 3'b000) begin failures++; $display("FAIL basic_flags got=%b exp=000", flags_q); end
        checks++; if (dbg_data !== 16'd2) begin failures++; $display("FAIL basic_dbg_r3 got=%h exp=0002", dbg_data); end
        @(negedge clk);
        #1;
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL basic_wb_pulse got=%b exp=0", wb_valid); end
    endtask

    task automatic test_back_to_back();
        int stalls;
        load_reg(3'd3, 16'h0100);
        instr_valid = 1'b1; instr_rd = 3'd3; instr_rs1 = 3'd1; instr_rs2 = 3'd2;
        @(negedge clk);
        instr_rd = 3'd4; instr_rs1 = 3'd3; instr_rs2 = 3'd1;
        #1;
        stalls = 0;
        while (!instr_ready && stalls < 4) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        checks++; if (stalls !== (BYP ? 0 : 1)) begin failures++; $display("FAIL b2b_stalls got=%0d exp=%0d", stalls, BYP ? 0 : 1); end
        @(negedge clk);
        instr_valid = 1'b0;
        #1;
        checks++; if (alu_in_a !== 16'd2) begin failures++; $display("FAIL b2b_in_a got=%h exp=0002", alu_in_a); end
        checks++; if (alu_in_b !== 16'd5) begin failures++; $display("FAIL b2b_in_b got=%h exp=0005", alu_in_b); end
        @(negedge clk);
        dbg_addr = 3'd4;
        #1;
        checks++; if (wb_valid !== 1'b1 || wb_addr !== 3'd4 || wb_data !== 16'd7) begin
            failures++; $display("FAIL b2b_wb got=%b/%h/%h exp=1/4/0007", wb_valid, wb_addr, wb_data); end
        checks++; if (dbg_data !== 16'd7) begin failures++; $display("FAIL b2b_dbg_r4 got=%h exp=0007", dbg_data); end
    endtask

    task automatic test_load_priority();
        @(negedge clk);
        ld_valid = 1'b1; ld_addr = 3'd5; ld_data = 16'd100;
        instr_valid = 1'b1; instr_rd = 3'd6; instr_rs1 = 3'd5; instr_rs2 = 3'd5;
        #1;
        checks++; if (instr_ready !== 1'b0) begin failures++; $display("FAIL prio_instr_ready got=%b exp=0", instr_ready); end
        checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL prio_ld_ready got=%b exp=1", ld_ready); end
        @(negedge clk);
        ld_valid = 1'b0;
        #1;
        checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL prio_next_ready got=%b exp=1", instr_ready); end
        @(negedge clk);
        instr_valid = 1'b0;
        #1;
        checks++; if (alu_in_a !== 16'd100) begin failures++; $display("FAIL prio_in_a got=%h exp=0064", alu_in_a); end
        checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL prio_ld_busy got=%b exp=0", ld_ready); end
        @(negedge clk);
        #1;
        checks++; if (wb_data !== 16'd200 || wb_addr !== 3'd6) begin failures++; $display("FAIL prio_wb got=%h/%h exp=6/00c8", wb_addr, wb_data); end
    endtask

    task automatic test_overflow();
        load_reg(3'd1, 16'h7FFF);
        load_reg(3'd2, 16'h0001);
        instr_valid = 1'b1; instr_opcode = 3'd5; instr_rd = 3'd7; instr_rs1 = 3'd1; instr_rs2 = 3'd2;
        @(negedge clk);
        instr_valid = 1'b0;
        ld_valid = 1'b1; ld_addr = 3'd0; ld_data = 16'h1234;
        #1;
        checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL ovf_ld_ready got=%b exp=0", ld_ready); end
        checks++; if (alu_opcode !== 3'd5) begin failures++; $display("FAIL ovf_opcode got=%h exp=5", alu_opcode); end
        @(negedge clk);
        ld_valid = 1'b0;
        #1;
        checks++; if (wb_data !== 16'h8000 || wb_addr !== 3'd7) begin failures++; $display("FAIL ovf_wb got=%h/%h exp=7/8000", wb_addr, wb_data); end
        checks++; if (flags_q !== 3'b110) begin failures++; $display("FAIL ovf_flags got=%b exp=110", flags_q); end
        @(negedge clk);
        dbg_addr = 3'd0;
        #1;
        checks++; if (dbg_data !== 16'd0) begin failures++; $display("FAIL ovf_blocked_load got=%h exp=0000", dbg_data); end
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        instr_valid = 1'b1; instr_opcode = 3'd3; instr_rd = 3'd6; instr_rs1 = 3'd1; instr_rs2 = 3'd2;
        @(posedge clk);
        #2;
        instr_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (alu_in_a !== 16'd0 || alu_in_b !== 16'd0 || alu_opcode !== 3'd0) begin
            failures++; $display("FAIL midrst_alu got=%h/%h/%h exp=0/0/0", alu_in_a, alu_in_b, alu_opcode); end
        checks++; if (flags_q !== 3'd0 || wb_valid !== 1'b0 || wb_addr !== 3'd0 || wb_data !== 16'd0) begin
            failures++; $display("FAIL midrst_wb got=%b/%b/%h/%h exp=0/0/0/0", flags_q, wb_valid, wb_addr, wb_data); end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL midrst_no_wb cycle%0d got=%b exp=0", c, wb_valid); end
        end
        for (int a = 0; a < NREGS; a++) begin
            @(negedge clk);
            dbg_addr = AW'(a);
            #1;
            checks++; if (dbg_data !== 16'd0) begin failures++; $display("FAIL midrst_dbg r%0d got=%h exp=0", a, dbg_data); end
        end
    endtask

    task automatic test_random();
        logic [15:0] aregs [NREGS];
        logic [15:0] cregs [NREGS];
        logic        a1v, a2v, lv, exp_ir, exp_lr;
        logic [2:0]  rd1, rd2, op1, fl1, fl2, exp_flags, la;
        logic [15:0] oa1, ob1, res1, res2, ld_d;
        logic [18:0] r;
        for (int i = 0; i < NREGS; i++) begin aregs[i] = 16'd0; cregs[i] = 16'd0; end
        a1v = 1'b0; a2v = 1'b0; lv = 1'b0; exp_flags = 3'd0;
        rd1 = '0; rd2 = '0; op1 = '0; fl1 = '0; fl2 = '0; la = '0;
        oa1 = '0; ob1 = '0; res1 = '0; res2 = '0; ld_d = '0;
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            ld_valid     = ($urandom_range(0, 3) == 0);
            ld_addr      = AW'($urandom_range(0, NREGS - 1));
            ld_data      = 16'($urandom);
            instr_valid  = ($urandom_range(0, 9) < 7);
            instr_opcode = 3'($urandom_range(0, 7));
            instr_rd     = AW'($urandom_range(0, NREGS - 1));
            instr_rs1    = AW'($urandom_range(0, NREGS - 1));
            instr_rs2    = AW'($urandom_range(0, NREGS - 1));
            dbg_addr     = AW'($urandom_range(0, NREGS - 1));
            #1;
            // effects of the previous edge on the visible register file
            if (a2v) cregs[rd2] = res2;
            if (lv) cregs[la] = ld_d;
            lv = 1'b0;
            if (a2v) exp_flags = fl2;
            checks++; if (wb_valid !== a2v) begin failures++; $display("FAIL rnd_wb_valid n=%0d got=%b exp=%b", n, wb_valid, a2v); end
            if (a2v) begin
                checks++; if (wb_addr !== rd2 || wb_data !== res2) begin
                    failures++; $display("FAIL rnd_wb n=%0d got=%h/%h exp=%h/%h", n, wb_addr, wb_data, rd2, res2); end
            end
            checks++; if (flags_q !== exp_flags) begin failures++; $display("FAIL rnd_flags n=%0d got=%b exp=%b", n, flags_q, exp_flags); end
            if (a1v) begin
                checks++; if (alu_in_a !== oa1 || alu_in_b !== ob1 || alu_opcode !== op1) begin
                    failures++; $display("FAIL rnd_operands n=%0d got=%h/%h/%h exp=%h/%h/%h", n, alu_in_a, alu_in_b, alu_opcode, oa1, ob1, op1); end
            end
            checks++; if (dbg_data !== cregs[dbg_addr]) begin failures++; $display("FAIL rnd_dbg n=%0d r%0d got=%h exp=%h", n, dbg_addr, dbg_data, cregs[dbg_addr]); end
            exp_lr = !a1v;
            exp_ir = !ld_valid && (BYP || !(a1v && (instr_rs1 == rd1 || instr_rs2 == rd1)));
            checks++; if (ld_ready !== exp_lr) begin failures++; $display("FAIL rnd_ld_ready n=%0d got=%b exp=%b", n, ld_ready, exp_lr); end
            checks++; if (instr_ready !== exp_ir) begin failures++; $display("FAIL rnd_instr_ready n=%0d got=%b exp=%b", n, instr_ready, exp_ir); end
            // architectural update in acceptance order
            a2v = a1v; rd2 = rd1; res2 = res1; fl2 = fl1;
            a1v = instr_valid && exp_ir;
            if (ld_valid && exp_lr) begin
                lv = 1'b1; la = ld_addr; ld_d = ld_data;
                aregs[ld_addr] = ld_data;
            end
            if (a1v) begin
                oa1 = aregs[instr_rs1];
                ob1 = aregs[instr_rs2];
                r = ref_add(oa1, ob1);
                res1 = r[15:0];
                fl1 = r[18:16];
                rd1 = instr_rd;
                op1 = instr_opcode;
                aregs[rd1] = res1;
            end
        end
        @(negedge clk);
        idle_inputs();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_back_to_back();
        test_load_priority();
        test_overflow();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
